// File: rtl/elastic_fifo_pkg.sv
// Shared types and helpers for the elastic FIFO.
// occ_e   : occupancy class derived from the entry count
// occ_of  : maps a count and a depth onto its occupancy class
package elastic_fifo_pkg;

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) return OccEmpty;
    if (cnt >= depth) return OccFull;
    return OccPartial;
  endfunction

endpackage

// File: rtl/elastic_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear and increment.
// Wraps explicitly from DEPTH-1 to 0, so DEPTH need not be a power of two.
// clk, rst : clock, asynchronous active-high reset
// clr      : synchronous clear (wins over inc)
// inc      : advance by one
// ptr      : current pointer value
module wrap_ptr #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/elastic_fifo.sv
// Multi-entry elastic buffer with registered ready/valid on both sides.
// Handshake flags are flops computed from the next count, so neither valid_in
// nor ready_in reaches any output combinationally; data_out is read straight
// from storage at the read pointer.
// clk, rst              : clock, asynchronous active-high reset
// flush                 : synchronous clear, beats a concurrent push
// valid_in/ready_out    : producer handshake, data_in payload
// valid_out/ready_in    : consumer handshake, data_out head payload
// count, almost_full    : occupancy and count >= AF_LEVEL
module elastic_fifo
  import elastic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned AF_LEVEL        = DEPTH - 1,
  parameter bit          GATING_FRIENDLY = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (DEPTH < 2) begin : gen_depth_chk
    $error("elastic_fifo: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gen_af_chk
    $error("elastic_fifo: AF_LEVEL must lie in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_d, count_q;
  logic                  valid_q, ready_q, af_q;
  logic                  valid_d, ready_d, af_d;
  logic                  push, pop, mem_we;
  occ_e                  occ_d;

  assign push = valid_in & ready_q;
  assign pop  = valid_q & ready_in;

  wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // With gating off the write slot is refreshed every ready cycle; the pointer
  // only advances on a real push, so an unaccepted write is overwritten later.
  assign mem_we = GATING_FRIENDLY ? (push & ~flush) : ready_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr] <= data_in;
  end

  assign data_out = mem_q[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    occ_d   = occ_of(32'(count_d), DEPTH);
    valid_d = (occ_d != OccEmpty);
    ready_d = (occ_d != OccFull);
    af_d    = (count_d >= CNT_W'(AF_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      af_q    <= af_d;
    end
  end

  assign count       = count_q;
  assign valid_out   = valid_q;
  assign ready_out   = ready_q;
  assign almost_full = af_q;

endmodule
